// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the RV32IM core: load-use stalls, taken-branch
// flushes and fixed-latency MUL/DIV sequencing, plus a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core_N,
  input  logic        id_valid_di,
  input  logic [4:0]  id_rs1_di,
  input  logic [4:0]  id_rs2_di,
  input  logic        id_rs1_used_di,
  input  logic        id_rs2_used_di,
  input  logic        ex_valid_di,
  input  logic [4:0]  ex_rd_di,
  input  logic        ex_is_load_di,
  input  logic        ex_is_md_di,
  input  logic        branch_taken_di,
  output logic        stall_fd_do,
  output logic        stall_ex_do,
  output logic        bubble_ex_do,
  output logic        flush_fd_do,
  output logic        md_start_do,
  output logic        md_busy_do,
  output logic        md_done_do,
  output logic [31:0] stall_cnt_do,
  output logic        fsm_state_dbg
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q;
  logic        lu_haz;

  assign lu_haz = ex_valid_di && ex_is_load_di && (ex_rd_di != 5'd0) && id_valid_di &&
                  ((id_rs1_used_di && (id_rs1_di == ex_rd_di)) ||
                   (id_rs2_used_di && (id_rs2_di == ex_rd_di)));

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    stall_fd_do  = 1'b0;
    stall_ex_do  = 1'b0;
    bubble_ex_do = 1'b0;
    flush_fd_do  = 1'b0;
    md_start_do  = 1'b0;
    md_busy_do   = 1'b0;
    md_done_do   = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken_di) begin
          flush_fd_do  = 1'b1;
          bubble_ex_do = 1'b1;
        end else if (ex_valid_di && ex_is_md_di) begin
          md_start_do = 1'b1;
          stall_fd_do = 1'b1;
          stall_ex_do = 1'b1;
          md_cnt_d    = MD_LOAD;
          state_d     = MD_BUSY;
        end else if (lu_haz) begin
          stall_fd_do  = 1'b1;
          bubble_ex_do = 1'b1;
        end
      end
      MD_BUSY: begin
        // EX holds the MD op, so branch and load-use inputs are irrelevant here
        md_busy_do  = 1'b1;
        stall_fd_do = 1'b1;
        stall_ex_do = 1'b1;
        if (md_cnt_q == 8'd0) begin
          md_done_do = 1'b1;
          state_d    = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
    // Outputs are held quiet for the whole reset assertion, not just after the edge
    if (!Rst_Core_N) begin
      stall_fd_do  = 1'b0;
      stall_ex_do  = 1'b0;
      bubble_ex_do = 1'b0;
      flush_fd_do  = 1'b0;
      md_start_do  = 1'b0;
      md_busy_do   = 1'b0;
      md_done_do   = 1'b0;
    end
  end

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q     <= RUN;
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      if (stall_fd_do && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_do  = stall_cnt_q;
  assign fsm_state_dbg = (state_q == MD_BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard cases, randomized RUN
// traffic, MUL/DIV sequencing, async reset mid-sequence and counter saturation.
module tb_hazard_ctrl;

  localparam logic [6:0] E_STALL_FD = 7'b1000000;
  localparam logic [6:0] E_STALL_EX = 7'b0100000;
  localparam logic [6:0] E_BUBBLE   = 7'b0010000;
  localparam logic [6:0] E_FLUSH    = 7'b0001000;
  localparam logic [6:0] E_START    = 7'b0000100;
  localparam logic [6:0] E_BUSY     = 7'b0000010;
  localparam logic [6:0] E_DONE     = 7'b0000001;

  logic        clk;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_valid, ex_is_load, ex_is_md, branch_taken;
  logic        stall_fd, stall_ex, bubble_ex, flush_fd, md_start, md_busy, md_done;
  logic [31:0] stall_cnt;
  logic        fsm_state;

  logic [6:0]  exp_q[$];
  logic [31:0] exp_cnt;
  int          n_checks;
  int          n_fail;

  hazard_ctrl #(.MD_CYCLES(32)) dut (
    .Clk_Core        (clk),
    .Rst_Core_N      (rst_n),
    .id_valid_di     (id_valid),
    .id_rs1_di       (id_rs1),
    .id_rs2_di       (id_rs2),
    .id_rs1_used_di  (id_rs1_used),
    .id_rs2_used_di  (id_rs2_used),
    .ex_valid_di     (ex_valid),
    .ex_rd_di        (ex_rd),
    .ex_is_load_di   (ex_is_load),
    .ex_is_md_di     (ex_is_md),
    .branch_taken_di (branch_taken),
    .stall_fd_do     (stall_fd),
    .stall_ex_do     (stall_ex),
    .bubble_ex_do    (bubble_ex),
    .flush_fd_do     (flush_fd),
    .md_start_do     (md_start),
    .md_busy_do      (md_busy),
    .md_done_do      (md_done),
    .stall_cnt_do    (stall_cnt),
    .fsm_state_dbg   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {stall_fd, stall_ex, bubble_ex, flush_fd, md_start, md_busy, md_done};
  endfunction

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic ld,
                        input logic md, input logic br);
    ex_valid = v; ex_rd = rd; ex_is_load = ld; ex_is_md = md; branch_taken = br;
  endtask

  // One clock: queue the expectation for the driven inputs, compare at negedge,
  // then advance the bench's own stall counter model past the edge.
  task automatic run_cycle(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq({tag, "_ctrl"}, {25'd0, ctrl_vec()}, {25'd0, e});
    check_eq({tag, "_cnt"}, stall_cnt, exp_cnt);
    @(posedge clk);
    #1;
    if (e[6] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic md_sequence(input string tag, input int inject_br_at);
    set_ex(1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    run_cycle({tag, "_start"}, E_STALL_FD | E_STALL_EX | E_START);
    for (int i = 0; i < 32; i++) begin
      branch_taken = (i == inject_br_at);
      run_cycle({tag, "_busy"}, E_STALL_FD | E_STALL_EX | E_BUSY | ((i == 31) ? E_DONE : 7'd0));
    end
    branch_taken = 1'b0;
  endtask

  initial begin
    logic [31:0] cnt_before;
    logic [6:0]  e;
    logic        lu;
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 32'd0;
    rst_n    = 1'b0;
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    set_ex(1'b1, 5'd5, 1'b0, 1'b1, 1'b1);
    #1;
    check_eq("reset_ctrl", {25'd0, ctrl_vec()}, 32'd0);
    check_eq("reset_cnt", stall_cnt, 32'd0);
    check_eq("reset_state", {31'd0, fsm_state}, 32'd0);
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // load-use on rs1, then the same with rd = x0
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1);
    set_ex(1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    run_cycle("lu_rs1", E_STALL_FD | E_BUBBLE);
    check_eq("lu_rs1_cnt1", stall_cnt, 32'd1);
    set_id(1'b1, 5'd0, 1'b1, 5'd1, 1'b1);
    set_ex(1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    run_cycle("lu_x0", 7'd0);

    // unused rs2 operand, then used rs2
    set_id(1'b1, 5'd3, 1'b1, 5'd7, 1'b0);
    set_ex(1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    run_cycle("lu_unused", 7'd0);
    id_rs2_used = 1'b1;
    run_cycle("lu_rs2", E_STALL_FD | E_BUBBLE);

    // branch beats load-use
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
    set_ex(1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    cnt_before = exp_cnt;
    run_cycle("br_prio", E_FLUSH | E_BUBBLE);
    check_eq("br_prio_cnt", stall_cnt, cnt_before);

    // randomized RUN traffic with a small register range to provoke matches
    for (int i = 0; i < 60; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      set_ex(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'b0, 1'($urandom_range(0, 3) == 0));
      lu = ex_valid && ex_is_load && (ex_rd != 5'd0) && id_valid &&
           ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
      e = branch_taken ? (E_FLUSH | E_BUBBLE) : (lu ? (E_STALL_FD | E_BUBBLE) : 7'd0);
      run_cycle("rand", e);
    end

    // DIV with a mid-sequence branch pulse, back-to-back with a second op
    set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1);
    cnt_before = exp_cnt;
    md_sequence("div", 12);
    check_eq("div_cnt_delta", stall_cnt - cnt_before, 32'd33);
    check_eq("div_state_run", {31'd0, fsm_state}, 32'd0);
    md_sequence("div_b2b", -1);
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    run_cycle("div_after", 7'd0);

    // async reset with md_cnt = 10
    set_ex(1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    run_cycle("rst_md_start", E_STALL_FD | E_STALL_EX | E_START);
    for (int i = 0; i < 21; i++)
      run_cycle("rst_md_busy", E_STALL_FD | E_STALL_EX | E_BUSY);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ctrl", {25'd0, ctrl_vec()}, 32'd0);
    check_eq("rst_mid_cnt", stall_cnt, 32'd0);
    check_eq("rst_mid_state", {31'd0, fsm_state}, 32'd0);
    exp_cnt = 32'd0;
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_cycle("rst_after", 7'd0);
    check_eq("rst_after_state", {31'd0, fsm_state}, 32'd0);

    // saturation: preload near max, then three stall cycles
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    set_ex(1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_cycle("sat", E_STALL_FD | E_BUBBLE);
    check_eq("sat_final", stall_cnt, 32'hFFFF_FFFF);
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    run_cycle("sat_idle", 7'd0);

    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the RV32IM core. It watches the decode stage and the execute stage and generates the stall, bubble and flush controls that sequence the fetch, decode and execute pipeline registers. It covers three cases: load-use hazards, taken-branch flushes, and multi-cycle M-extension operations, which hold the execute stage for a fixed number of cycles. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MD_CYCLES, 32, number of busy cycles a MUL/DIV op occupies EX after its start cycle (legal range 1..255).
- Clk_Core  in  1  core clock.
- Rst_Core_N  in  1  reset; asynchronous, active-low.
- id_valid_di  in  1  decode stage holds a valid instruction.
- id_rs1_di / id_rs2_di  in  5  decode source register addresses.
- id_rs1_used_di / id_rs2_used_di  in  1  source register is actually read by the decode instruction.
- ex_valid_di  in  1  execute stage holds a valid instruction.
- ex_rd_di  in  5  execute destination register.
- ex_is_load_di  in  1  execute instruction is a load.
- ex_is_md_di  in  1  execute instruction is MUL/MULH*/DIV*/REM*.
- branch_taken_di  in  1  execute resolved a taken branch or jump this cycle.
- stall_fd_do  out  1  hold the fetch PC and the decode pipeline registers.
- stall_ex_do  out  1  hold the execute pipeline register.
- bubble_ex_do  out  1  load a NOP into the execute register at the next edge.
- flush_fd_do  out  1  invalidate the fetch output and the decode register contents at the next edge.
- md_start_do  out  1  one-cycle pulse that starts the multiplier/divider.
- md_busy_do  out  1  the multiplier/divider sequence is in progress.
- md_done_do  out  1  one-cycle pulse; the MUL/DIV result is valid this cycle.
- stall_cnt_do  out  32  count of cycles with stall_fd_do=1; saturates at 32'hFFFF_FFFF.

## Operation
- FSM has two states: RUN and MD_BUSY. The down-counter md_cnt is 8 bits wide.
- Load-use hazard, lu_haz, is true when all of the following hold:
  - ex_valid_di & ex_is_load_di & (ex_rd_di != 0) & id_valid_di;
  - and either (id_rs1_used_di & id_rs1_di == ex_rd_di) or (id_rs2_used_di & id_rs2_di == ex_rd_di).
- RUN, evaluated in priority order:
  1. branch_taken_di: flush_fd_do=1 and bubble_ex_do=1; no stall; stay in RUN.
  2. ex_valid_di & ex_is_md_di: md_start_do=1, stall_fd_do=1, stall_ex_do=1; load md_cnt <= MD_CYCLES-1; go to MD_BUSY.
  3. lu_haz: stall_fd_do=1 and bubble_ex_do=1 for exactly this cycle. The load then moves on to MEM, so lu_haz clears on its own.
  4. Otherwise all control outputs are 0.
- MD_BUSY:
  - md_busy_do=1, stall_fd_do=1, stall_ex_do=1 every cycle.
  - branch_taken_di and lu_haz are ignored, since EX holds a non-branch, non-load op.
  - If md_cnt==0: md_done_do=1 and the next state is RUN. Otherwise md_cnt decrements.
- All control outputs are combinational from the state, md_cnt and the inputs.
- stall_cnt_do is a registered counter: it increments at each edge where stall_fd_do=1, unless it is already saturated.
- While Rst_Core_N=0:
  - state=RUN, md_cnt=0, stall_cnt_do=0;
  - every control output is forced to 0, whatever the inputs are.

## Timing
- Load-use: exactly 1 stall cycle plus 1 bubble. The dependent instruction issues to EX on the following cycle.
- Branch: 0 stall cycles. The two younger instructions (in fetch and in decode) are killed by flush_fd_do plus bubble_ex_do in the same cycle.
- MUL/DIV: EX is held for 1 + MD_CYCLES cycles (the start cycle plus MD_BUSY). md_done_do fires in the last held cycle. The op leaves EX at the edge that ends that cycle.
- Back-to-back MUL/DIV: the next MD op enters EX after RUN is re-entered, and it starts in its first RUN cycle. There is no dead cycle beyond the pipeline advance.
- If reset is asserted mid-MD_BUSY: the state returns to RUN asynchronously, and md_busy_do and the stall outputs drop immediately. No md_done_do is generated.
- MD_CYCLES=1: MD_BUSY lasts one cycle, and md_done_do is asserted in that cycle.

## Test plan
- Load-use on rs1: EX has a load to x5, ID reads rs1=x5 (used) -> stall_fd_do=1 and bubble_ex_do=1 for one cycle; stall_cnt_do goes from 0 to 1. Repeat with rd=x0 -> no stall.
- Unused operand: EX has a load to x7, ID has rs2=x7 with id_rs2_used_di=0 -> no stall, no bubble.
- Branch priority: branch_taken_di=1 in the same cycle as a lu_haz match -> flush_fd_do=1, bubble_ex_do=1, stall_fd_do=0; stall_cnt_do unchanged.
- DIV sequence with MD_CYCLES=32, from the cycle EX gets a DIV:
  - md_start_do pulses once and md_busy_do stays high for 32 cycles;
  - stalls are held for 33 cycles in total, md_done_do fires on cycle 33, and stall_cnt_do rises by 33;
  - a branch_taken_di pulse injected mid-sequence has no effect.
- Reset during MD_BUSY: assert Rst_Core_N=0 with md_cnt=10 -> all outputs go to 0 at once, stall_cnt_do=0; after release, the FSM is in RUN.
- Saturation: preload stall_cnt_do near its maximum by forcing it to 32'hFFFF_FFFE, then hold a 3-cycle stall -> the counter ends at 32'hFFFF_FFFF.
